// File: rtl/rv32_dmem_responder.sv
// RV32 data-memory responder: a single outstanding request, a fixed response latency,
// and byte/halfword/word loads and stores with alignment and range checking.
module rv32_dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [65:0] req_pkt,
  input  logic [4:0]  req_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        read_enable;
    logic        write_enable;
  } mem_pkt_t;

  typedef struct packed {
    logic [2:0] load_type;
    logic [1:0] store_type;
  } ex_ctrl_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_pkt_t    pkt_q, pkt_d;
  ex_ctrl_t    ctrl_q, ctrl_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH];

  mem_pkt_t    op_pkt;
  ex_ctrl_t    op_ctrl;
  logic [IW-1:0] idx;
  logic [1:0]  lane;
  logic [31:0] rd_word, ld_val, wmask, wdata, wr_word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        is_rd, is_wr, is_half, is_word, type_err, range_err, access_err;
  logic        enter_resp, mem_we;

  // The access is decoded from the live request when it goes straight to RESP
  // (LATENCY==1), otherwise from the captured copy.
  always_comb begin
    op_pkt    = (state_q == IDLE) ? mem_pkt_t'(req_pkt) : pkt_q;
    op_ctrl   = (state_q == IDLE) ? ex_ctrl_t'(req_ctrl) : ctrl_q;
    is_rd     = op_pkt.read_enable & ~op_pkt.write_enable;
    is_wr     = op_pkt.write_enable & ~op_pkt.read_enable;
    idx       = op_pkt.addr[IW+1:2];
    lane      = op_pkt.addr[1:0];
    rd_word   = mem[idx];
    byte_v    = rd_word[{lane, 3'b000} +: 8];
    half_v    = lane[1] ? rd_word[31:16] : rd_word[15:0];
    is_half   = 1'b0;
    is_word   = 1'b0;
    type_err  = 1'b0;
    ld_val    = '0;
    wmask     = '0;
    wdata     = '0;
    if (is_rd) begin
      case (op_ctrl.load_type)
        3'd0: ld_val = {{24{byte_v[7]}}, byte_v};
        3'd1: begin is_half = 1'b1; ld_val = {{16{half_v[15]}}, half_v}; end
        3'd2: begin is_word = 1'b1; ld_val = rd_word; end
        3'd3: ld_val = {24'd0, byte_v};
        3'd4: begin is_half = 1'b1; ld_val = {16'd0, half_v}; end
        default: type_err = 1'b1;
      endcase
    end
    if (is_wr) begin
      case (op_ctrl.store_type)
        2'd0: begin
          wmask = 32'h0000_00FF << {lane, 3'b000};
          wdata = {4{op_pkt.data[7:0]}};
        end
        2'd1: begin
          is_half = 1'b1;
          wmask   = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
          wdata   = {2{op_pkt.data[15:0]}};
        end
        2'd2: begin
          is_word = 1'b1;
          wmask   = '1;
          wdata   = op_pkt.data;
        end
        default: type_err = 1'b1;
      endcase
    end
    range_err  = {2'b00, op_pkt.addr[31:2]} >= 32'(DEPTH);
    access_err = ~(is_rd | is_wr) | type_err | (is_half & lane[0]) |
                 (is_word & (lane != 2'b00)) | range_err;
    wr_word    = (rd_word & ~wmask) | (wdata & wmask);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pkt_d      = pkt_q;
    ctrl_d     = ctrl_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pkt_d  = mem_pkt_t'(req_pkt);
          ctrl_d = ex_ctrl_t'(req_ctrl);
          cnt_d  = 4'(LATENCY - 1);
          if (LATENCY == 1) enter_resp = 1'b1;
          else              state_d    = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d      = '0;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d    = IDLE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      state_d    = RESP;
      rsp_err_d  = access_err;
      rsp_data_d = (access_err || !is_rd) ? '0 : ld_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pkt_q      <= '0;
      ctrl_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pkt_q      <= pkt_d;
      ctrl_q     <= ctrl_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Array is never cleared; a reset landing on the RESP-entry edge suppresses the write.
  assign mem_we = enter_resp & is_wr & ~access_err & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/rv32_dmem_responder.md
RV32_DMEM_RESPONDER -- requirements
Module: rv32_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, 1024, number of 32-bit words in the data array (power of two).
REQ-002 SHALL have parameter LATENCY, 2, cycles from request acceptance to rsp_valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_pkt  input  66  rv32_mem_packet_t: addr, data, read_enable, write_enable.
REQ-008 SHALL have port req_ctrl  input  5  rv32_ex_control_packet_t: load_type, store_type.
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-011 SHALL have port rsp_data  output  32  extended load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  output  1  request rejected; no array change.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = (state==IDLE).
REQ-014 SHALL accept a request when req_valid && req_ready, capturing req_pkt and req_ctrl, loading a countdown with LATENCY-1, and moving to WAIT (LATENCY>1) or directly to RESP (LATENCY==1).
REQ-015 SHALL decrement the countdown each WAIT cycle and enter RESP when it reaches 0, so rsp_valid first rises exactly LATENCY cycles after the acceptance edge.
REQ-016 SHALL perform the array read/write on the edge entering RESP; a store is visible to any later-accepted load.
REQ-017 SHALL hold rsp_valid, rsp_data, rsp_err stable in RESP until rsp_ready; on handshake return to IDLE (next acceptance no earlier than the following cycle).
REQ-018 SHALL decode load_type 0=LB, 1=LH, 2=LW, 3=LBU, 4=LHU; 5..7 -> error.
REQ-019 SHALL decode store_type 0=SB, 1=SH, 2=SW; 3 -> error.
REQ-020 SHALL select bytes little-endian: word index addr[31:2], byte lane addr[1:0], halfword lane addr[1].
REQ-021 SHALL sign-extend LB/LH and zero-extend LBU/LHU to 32 bits.
REQ-022 SHALL write only addressed lanes: SB data[7:0], SH data[15:0], SW data[31:0]; other lanes unchanged.
REQ-023 SHALL flag rsp_err=1, rsp_data=0, no write when: halfword op with addr[0]=1; word op with addr[1:0]!=0; addr[31:2] >= DEPTH; both or neither enable set; illegal type code.
REQ-024 SHALL ignore store_type on reads and load_type on writes.
REQ-025 SHALL ignore req_valid while not IDLE (request not consumed).
REQ-026 SHALL assert rsp_valid only in RESP; rsp_data/rsp_err SHALL be 0 outside RESP.

Reset
REQ-027 SHALL on rst force state IDLE, countdown 0, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-028 SHALL, if rst asserts in WAIT, abandon the request with no array write and no response.
REQ-029 SHALL NOT reset array contents; contents persist across rst.

Verification
REQ-030 SW 0x0000_0010 data 0xDEAD_BEEF, then LW 0x10 -> store response err=0 data=0 at acceptance+2; load rsp_data=0xDEADBEEF at acceptance+2.
REQ-031 After REQ-030, SB addr 0x11 data 0x0000_0080, then LB 0x11 -> 0xFFFF_FF80; LBU 0x11 -> 0x0000_0080; LW 0x10 -> 0xDEAD_80EF.
REQ-032 LH addr 0x13 and SW addr 0x12 -> rsp_err=1, rsp_data=0; subsequent LW 0x10 unchanged (0xDEAD_80EF).
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable all 5 cycles, req_ready=0; new req_valid not accepted until cycle after handshake.
REQ-034 Accept SW 0x20 data 0x1234_5678 with LATENCY=3, assert rst one cycle later -> no response, req_ready=1 after reset; LW 0x20 returns prior contents.
REQ-035 LW addr 4*DEPTH (out of range) and request with read_enable=write_enable=1 -> rsp_err=1, no array change.
